// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared constants and state type for the float adder normalise/round stage
package fadd_pkg;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 5;
    localparam int EXP_MAX  = 255;
    localparam int EXP_BIAS = 127;

    // Extended mantissa layout: carry, hidden, fraction, guard, round, sticky
    localparam int BIT_CARRY  = 27;
    localparam int BIT_HIDDEN = 26;
    localparam int BIT_LSB    = 3;
    localparam int BIT_G      = 2;
    localparam int BIT_R      = 1;
    localparam int BIT_S      = 0;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;
endpackage

// File: rtl/fadd_norm_round_if.sv
// rtl/fadd_norm_round_if.sv - operand/result handshake bundle for the normalise/round stage
interface fadd_norm_round_if #(
    parameter int EXP_W  = fadd_pkg::EXP_W,
    parameter int FRAC_W = fadd_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [MANT_W-1:0]       in_mant;
    logic                    in_sticky;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   result;
    logic                    overflow;
    logic                    underflow;
    logic                    zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
        output in_ready, out_valid, result, overflow, underflow, zero
    );
endinterface

// File: rtl/fadd_rne_round.sv
// rtl/fadd_rne_round.sv - combinational round-to-nearest-even on a normalised extended mantissa
module fadd_rne_round #(
    parameter int EXP_W  = fadd_pkg::EXP_W,
    parameter int MANT_W = fadd_pkg::MANT_W
) (
    input  logic [MANT_W-1:0] mant,
    input  logic [EXP_W:0]    expIn,
    output logic [MANT_W-1:0] mantOut,
    output logic [EXP_W:0]    expOut,
    output logic              overflow
);
    import fadd_pkg::*;

    localparam logic [EXP_W:0] EXP_ONE   = 1;
    localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W+1)'(EXP_MAX);

    logic              inc;
    logic [MANT_W-1:0] incVec;
    logic [MANT_W-1:0] sum;

    always_comb begin
        inc            = mant[BIT_G] & (mant[BIT_R] | mant[BIT_S] | mant[BIT_LSB]);
        incVec         = '0;
        incVec[BIT_LSB] = inc;
        sum            = mant + incVec;
        mantOut        = sum;
        expOut         = expIn;
        // A carry out of the hidden bit renormalises with the dropped bit folded into sticky
        if (sum[MANT_W-1]) begin
            mantOut = {1'b0, sum[MANT_W-1:2], sum[1] | sum[0]};
            expOut  = expIn + EXP_ONE;
        end
        overflow = (expOut >= EXP_LIMIT);
    end
endmodule

// File: rtl/fadd_norm_round.sv
// rtl/fadd_norm_round.sv - bit-serial normalise then RNE round of a raw float sum, valid/ready framed
module fadd_norm_round #(
    parameter int EXP_W  = fadd_pkg::EXP_W,
    parameter int FRAC_W = fadd_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 5
) (
    input  logic             clock,
    input  logic             reset_n,
    fadd_norm_round_if.slave bus
);
    import fadd_pkg::*;

    localparam int             CARRY   = MANT_W - 1;
    localparam int             HIDDEN  = MANT_W - 2;
    localparam logic [EXP_W:0] EXP_ONE = 1;

    state_t                state;
    state_t                stateNext;
    logic                  signReg;
    logic [EXP_W:0]        expReg;
    logic [MANT_W-1:0]     mantReg;
    logic [EXP_W+FRAC_W:0] resultReg;
    logic                  ovfReg;
    logic                  unfReg;
    logic                  zeroReg;

    logic                  mantZero;
    logic                  mantCarry;
    logic                  mantLow;
    logic                  expAboveOne;
    logic [MANT_W-1:0]     roundMant;
    logic [EXP_W:0]        roundExp;
    logic                  roundOvf;

    assign mantZero    = (mantReg == '0);
    assign mantCarry   = mantReg[CARRY];
    assign mantLow     = (mantReg[CARRY:HIDDEN] == 2'b00);
    assign expAboveOne = (expReg > EXP_ONE);

    fadd_rne_round #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_round (
        .mant     (mantReg),
        .expIn    (expReg),
        .mantOut  (roundMant),
        .expOut   (roundExp),
        .overflow (roundOvf)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (bus.in_valid) stateNext = NORM;
            NORM: begin
                if (mantZero)       stateNext = DONE;
                else if (mantCarry) stateNext = NORM;
                else if (mantLow)   stateNext = expAboveOne ? NORM : DONE;
                else                stateNext = ROUND;
            end
            ROUND: stateNext = DONE;
            DONE:  if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.result    = resultReg;
        bus.overflow  = ovfReg;
        bus.underflow = unfReg;
        bus.zero      = zeroReg;
    end

    // One normalisation step per cycle; the NORM branch order mirrors the next-state priority
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            signReg   <= 1'b0;
            expReg    <= '0;
            mantReg   <= '0;
            resultReg <= '0;
            ovfReg    <= 1'b0;
            unfReg    <= 1'b0;
            zeroReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        signReg <= bus.in_sign;
                        expReg  <= {1'b0, bus.in_exp};
                        mantReg <= {bus.in_mant[MANT_W-1:1], bus.in_mant[0] | bus.in_sticky};
                    end
                end
                NORM: begin
                    if (mantZero) begin
                        zeroReg   <= 1'b1;
                        resultReg <= '0;
                    end else if (mantCarry) begin
                        mantReg <= {1'b0, mantReg[MANT_W-1:2], mantReg[1] | mantReg[0]};
                        expReg  <= expReg + EXP_ONE;
                    end else if (mantLow && expAboveOne) begin
                        mantReg <= {mantReg[MANT_W-2:0], 1'b0};
                        expReg  <= expReg - EXP_ONE;
                    end else if (mantLow) begin
                        unfReg    <= 1'b1;
                        resultReg <= {signReg, {(EXP_W+FRAC_W){1'b0}}};
                    end
                end
                ROUND: begin
                    mantReg   <= roundMant;
                    expReg    <= roundExp;
                    ovfReg    <= roundOvf;
                    resultReg <= roundOvf ? {signReg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                                          : {signReg, roundExp[EXP_W-1:0], roundMant[MANT_W-3:3]};
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ovfReg  <= 1'b0;
                        unfReg  <= 1'b0;
                        zeroReg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fadd_norm_round.sv
// tb/tb_fadd_norm_round.sv - self-checking bench for fadd_norm_round against a value-level model
module tb_fadd_norm_round;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fadd_norm_round_if bus ();

    fadd_norm_round dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic        st;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    // Value-level reference: normalise by counting leading zeros, round by remainder comparison
    function automatic void ref_model(input logic s, input logic [7:0] e, input logic [27:0] m,
                                      input logic st, output logic [31:0] r,
                                      output logic [2:0] fl, output int lat);
        int v, ex, d, maxShift, tmp, kept, rem;
        v  = int'(m) | int'(st);
        ex = int'(e);
        fl = 3'b000;
        if (v == 0) begin
            r = 32'h0; fl = 3'b001; lat = 1;
            return;
        end
        if (v >= (1 << 27)) begin
            v   = (v >> 1) | (v & 1);
            ex  = ex + 1;
            lat = 3;
        end else begin
            d = 0; tmp = v;
            while (tmp < (1 << 26)) begin
                tmp = tmp << 1;
                d++;
            end
            maxShift = (ex > 1) ? ex - 1 : 0;
            if (d > maxShift) begin
                r = {s, 31'h0}; fl = 3'b010; lat = maxShift + 1;
                return;
            end
            v = tmp; ex = ex - d; lat = d + 2;
        end
        kept = v >> 3;
        rem  = v & 7;
        if (rem > 4 || (rem == 4 && (kept & 1) == 1)) kept = kept + 1;
        if (kept >= (1 << 24)) begin
            kept = kept >> 1;
            ex   = ex + 1;
        end
        if (ex >= 255) begin
            r = {s, 8'hFF, 23'h0}; fl = 3'b100;
        end else begin
            r = {s, 8'(ex), 23'(kept)};
        end
    endfunction

    task automatic drive_op(input logic s, input logic [7:0] e, input logic [27:0] m, input logic st,
                            output logic [31:0] r, output logic [2:0] fl, output int lat);
        @(negedge clock);
        for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mant   = m;
        bus.in_sticky = st;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        r  = bus.result;
        fl = {bus.overflow, bus.underflow, bus.zero};
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 00000000", bus.result);
        end
        checks++;
        if ({bus.overflow, bus.underflow, bus.zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.overflow, bus.underflow, bus.zero});
        end
    endtask

    task automatic test_directed();
        vec_t        vecs [9];
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        vecs[0] = '{1'b0, 8'd127, 28'h8000000, 1'b0, 32'h40000000, 3'b000, 3};
        vecs[1] = '{1'b0, 8'd130, 28'h0000008, 1'b0, 32'h35800000, 3'b000, 25};
        vecs[2] = '{1'b0, 8'd127, 28'h4000004, 1'b0, 32'h3F800000, 3'b000, 2};
        vecs[3] = '{1'b0, 8'd127, 28'h4000004, 1'b1, 32'h3F800001, 3'b000, 2};
        vecs[4] = '{1'b0, 8'd127, 28'h400000C, 1'b0, 32'h3F800002, 3'b000, 2};
        vecs[5] = '{1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 32'h40000000, 3'b000, 2};
        vecs[6] = '{1'b0, 8'd254, 28'h8000000, 1'b0, 32'h7F800000, 3'b100, 3};
        vecs[7] = '{1'b1, 8'd100, 28'h0000000, 1'b0, 32'h00000000, 3'b001, 1};
        vecs[8] = '{1'b1, 8'd1,   28'h2000000, 1'b0, 32'h80000000, 3'b010, 1};
        for (int i = 0; i < 9; i++) begin
            drive_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].st, r, fl, lat);
            checks++;
            if (r !== vecs[i].res) begin
                errors++; $display("FAIL directed_result[%0d] got %h want %h", i, r, vecs[i].res);
            end
            checks++;
            if (fl !== vecs[i].fl) begin
                errors++; $display("FAIL directed_flags[%0d] got %b want %b", i, fl, vecs[i].fl);
            end
            checks++;
            if (lat !== vecs[i].lat) begin
                errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic        s, st;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] r, er;
        logic [2:0]  fl, efl;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            s  = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 254));
            m  = 28'(($urandom() & 32'h0FFFFFFF) >> $urandom_range(0, 28));
            ref_model(s, e, m, st, er, efl, elat);
            drive_op(s, e, m, st, r, fl, lat);
            checks++;
            if (r !== er) begin
                errors++; $display("FAIL random_result[%0d] e=%0d m=%h st=%b got %h want %h", i, e, m, st, r, er);
            end
            checks++;
            if (fl !== efl) begin
                errors++; $display("FAIL random_flags[%0d] got %b want %b", i, fl, efl);
            end
            checks++;
            if (lat !== elat) begin
                errors++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, elat);
            end
        end
    endtask

    task automatic test_hold_and_ignore();
        int waited;
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd127;
        bus.in_mant   = 28'h8000000;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clock);
        // Keep offering a different operand while busy; it must be ignored
        #1 bus.in_mant = 28'h0000000;
        bus.in_sign = 1'b1;
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            @(posedge clock);
            #1 waited++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL hold_out_valid_timeout got %b want 1", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (bus.result !== 32'h40000000) begin
                errors++; $display("FAIL hold_result[%0d] got %h want 40000000", i, bus.result);
            end
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, bus.out_valid);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_midop();
        int          spurious;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd130;
        bus.in_mant   = 28'h0000008;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++; $display("FAIL midreset_result got %h want 00000000", bus.result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        spurious = 0;
        repeat (30) begin
            @(posedge clock);
            #1 if (bus.out_valid) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++; $display("FAIL midreset_discard got %0d valid cycles want 0", spurious);
        end
        drive_op(1'b0, 8'd127, 28'h8000000, 1'b0, r, fl, lat);
        checks++;
        if (r !== 32'h40000000) begin
            errors++; $display("FAIL midreset_recover got %h want 40000000", r);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        test_directed();
        test_random();
        test_hold_and_ignore();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
